// File: rtl/mttkrp_pkg.sv
// Shared types for the MTTKRP datapath blocks.
package mttkrp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } row_acc_state_t;

endpackage

// File: rtl/rank_vec_add.sv
// Combinational element-wise adder over a rank-wide vector; each lane wraps modulo 2^N.
module rank_vec_add #(
  parameter int RANK_FACTOR_MATRIX = 16,
  parameter int N                  = 32
) (
  input  logic [RANK_FACTOR_MATRIX-1:0][N-1:0] a,
  input  logic [RANK_FACTOR_MATRIX-1:0][N-1:0] b,
  output logic [RANK_FACTOR_MATRIX-1:0][N-1:0] sum
);

  for (genvar j = 0; j < RANK_FACTOR_MATRIX; j++) begin : g_lane
    // Lanes are independent: no carry crosses an element boundary.
    assign sum[j] = a[j] + b[j];
  end

endmodule

// File: rtl/mttkrp_row_accum.sv
// Merges consecutive same-index partial-sum vectors into one output row,
// emitting on index change or last-marker, with valid/ready on both sides.
module mttkrp_row_accum
  import mttkrp_pkg::*;
#(
  parameter int RANK_FACTOR_MATRIX = 16,
  parameter int N                  = 32,
  parameter int IDX_W              = 20,
  parameter int CNT_W              = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_avl,
  output logic                                 in_rdy,
  input  logic [IDX_W-1:0]                     in_idx,
  input  logic                                 in_last,
  input  logic [RANK_FACTOR_MATRIX-1:0][N-1:0] in_data,
  output logic                                 out_avl,
  input  logic                                 out_rdy,
  output logic [IDX_W-1:0]                     out_idx,
  output logic [CNT_W-1:0]                     out_cnt,
  output logic [RANK_FACTOR_MATRIX-1:0][N-1:0] out_data
);

  typedef logic [RANK_FACTOR_MATRIX-1:0][N-1:0] vec_t;

  row_acc_state_t   state_q, state_d;
  vec_t             acc_q, acc_d;
  logic [IDX_W-1:0] acc_idx_q, acc_idx_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             out_avl_q, out_avl_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  vec_t             out_data_q, out_data_d;

  logic             slot_free, accept, same_idx;
  logic [CNT_W-1:0] cnt_inc;
  vec_t             sum_vec;

  logic             emit, load_beat, acc_add;
  logic [IDX_W-1:0] emit_idx;
  logic [CNT_W-1:0] emit_cnt;
  vec_t             emit_data;

  rank_vec_add #(
    .RANK_FACTOR_MATRIX (RANK_FACTOR_MATRIX),
    .N                  (N)
  ) u_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (sum_vec)
  );

  // in_rdy is gated even for same-index beats, keeping it independent of in_idx.
  assign slot_free = ~out_avl_q | out_rdy;
  assign in_rdy    = (state_q != DRAIN) & slot_free;
  assign accept    = in_avl & in_rdy;
  assign same_idx  = (in_idx == acc_idx_q);
  assign cnt_inc   = (acc_cnt_q == {CNT_W{1'b1}}) ? acc_cnt_q : acc_cnt_q + CNT_W'(1);

  assign out_avl  = out_avl_q;
  assign out_idx  = out_idx_q;
  assign out_cnt  = out_cnt_q;
  assign out_data = out_data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_idx_q  <= '0;
      acc_cnt_q  <= '0;
      out_avl_q  <= 1'b0;
      out_idx_q  <= '0;
      out_cnt_q  <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_idx_q  <= acc_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      out_avl_q  <= out_avl_d;
      out_idx_q  <= out_idx_d;
      out_cnt_q  <= out_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !in_last) state_d = ACC;
      ACC:     if (accept && in_last)  state_d = same_idx ? IDLE : DRAIN;
      DRAIN:   if (slot_free)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    load_beat = 1'b0;
    acc_add   = 1'b0;
    emit_idx  = acc_idx_q;
    emit_cnt  = acc_cnt_q;
    emit_data = acc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            emit      = 1'b1;
            emit_idx  = in_idx;
            emit_cnt  = CNT_W'(1);
            emit_data = in_data;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      ACC: begin
        if (accept) begin
          if (same_idx && in_last) begin
            emit      = 1'b1;
            emit_cnt  = cnt_inc;
            emit_data = sum_vec;
          end else if (same_idx) begin
            acc_add = 1'b1;
          end else begin
            // Old row leaves on the same edge the new index is loaded.
            emit      = 1'b1;
            load_beat = 1'b1;
          end
        end
      end
      DRAIN:   emit = slot_free;
      default: ;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    acc_idx_d  = acc_idx_q;
    acc_cnt_d  = acc_cnt_q;
    out_avl_d  = out_avl_q;
    out_idx_d  = out_idx_q;
    out_cnt_d  = out_cnt_q;
    out_data_d = out_data_q;

    if (load_beat) begin
      acc_d     = in_data;
      acc_idx_d = in_idx;
      acc_cnt_d = CNT_W'(1);
    end else if (acc_add) begin
      acc_d     = sum_vec;
      acc_cnt_d = cnt_inc;
    end

    // emit only fires when the slot is free, so a held row is never overwritten.
    if (emit) begin
      out_avl_d  = 1'b1;
      out_idx_d  = emit_idx;
      out_cnt_d  = emit_cnt;
      out_data_d = emit_data;
    end else if (out_rdy) begin
      out_avl_d = 1'b0;
    end
  end

endmodule
